// File: rtl/debounce_multi_pkg.sv
// Shared constants and helpers for the multi-channel debouncer.
// Optional feature macro (used by debounce_multi_chan): DEBOUNCE_LONG_PRESS_EN.
package debounce_multi_pkg;

    // Number of flops in each input synchroniser.
    localparam int SYNC_STAGES = 2;

    // All-ones value of a w-bit counter, i.e. its saturation point.
    function automatic longint unsigned max_count(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/debounce_multi_chan.sv
// One debounce channel: 2-flop synchroniser, stability counter, debounced
// level with rise/fall strobes, and an optional long-press detector.
// Optional feature macro: DEBOUNCE_LONG_PRESS_EN (long_press tied to 0 when undefined).
module debounce_multi_chan
    import debounce_multi_pkg::*;
#(
    parameter int   CNT_WIDTH  = 6,
    parameter logic RST_VAL    = 1'b0,
    parameter int   HOLD_WIDTH = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic state,
    output logic rise,
    output logic fall,
    output logic long_press
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(max_count(CNT_WIDTH));

    // Saturating increment for the stability counter.
    function automatic logic [CNT_WIDTH-1:0] cnt_sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    logic [SYNC_STAGES-1:0] sync_p0;   // [0] first flop, [SYNC_STAGES-1] metastability-safe output
    logic                   s2;
    logic [CNT_WIDTH-1:0]   cnt_p1;
    logic                   state_p1;
    logic                   rise_p1;
    logic                   fall_p1;

    assign s2 = sync_p0[SYNC_STAGES-1];

    // Stage p0: bring the raw pin into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], btn};
        end
    end

    // Stage p1: accept a new level only after it has differed from the
    // current level for 2**CNT_WIDTH consecutive cycles; strobe on acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_p1   <= '0;
            state_p1 <= RST_VAL;
            rise_p1  <= 1'b0;
            fall_p1  <= 1'b0;
        end else begin
            rise_p1 <= 1'b0;
            fall_p1 <= 1'b0;
            if (s2 == state_p1) begin
                cnt_p1 <= '0;
            end else if (cnt_p1 != CNT_MAX) begin
                cnt_p1 <= cnt_sat_inc(cnt_p1);
            end else begin
                state_p1 <= s2;
                cnt_p1   <= '0;
                rise_p1  <= s2;
                fall_p1  <= ~s2;
            end
        end
    end

    assign state = state_p1;
    assign rise  = rise_p1;
    assign fall  = fall_p1;

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam logic [HOLD_WIDTH-1:0] HOLD_MAX = HOLD_WIDTH'(max_count(HOLD_WIDTH));

    // Saturating increment for the hold counter.
    function automatic logic [HOLD_WIDTH-1:0] hold_sat_inc(input logic [HOLD_WIDTH-1:0] v);
        return (v == HOLD_MAX) ? v : v + 1'b1;
    endfunction

    logic [HOLD_WIDTH-1:0] hold_p2;
    logic                  lp_p2;

    // Stage p2: time how long the channel sits in its active level; one
    // strobe when the count first reaches its maximum, then it saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_p2 <= '0;
            lp_p2   <= 1'b0;
        end else begin
            lp_p2 <= 1'b0;
            if (state_p1 != RST_VAL) begin
                if (hold_p2 != HOLD_MAX) begin
                    hold_p2 <= hold_sat_inc(hold_p2);
                    lp_p2   <= (hold_p2 == HOLD_MAX - 1'b1);
                end
            end else begin
                hold_p2 <= '0;
            end
        end
    end

    assign long_press = lp_p2;
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: rtl/debounce_multi.sv
// N-channel debouncer: one independent debounce_multi_chan per button.
// Optional feature macro: DEBOUNCE_LONG_PRESS_EN (enables long_press strobes).
module debounce_multi
    import debounce_multi_pkg::*;
#(
    parameter int   N          = 4,
    parameter int   CNT_WIDTH  = 6,
    parameter logic RST_VAL    = 1'b0,
    parameter int   HOLD_WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] btn,
    output logic [N-1:0] state,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic [N-1:0] long_press
);

    // One channel per button; no state is shared between channels.
    for (genvar i = 0; i < N; i++) begin : g_chan
        debounce_multi_chan #(
            .CNT_WIDTH (CNT_WIDTH),
            .RST_VAL   (RST_VAL),
            .HOLD_WIDTH(HOLD_WIDTH)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .btn       (btn[i]),
            .state     (state[i]),
            .rise      (rise[i]),
            .fall      (fall[i]),
            .long_press(long_press[i])
        );
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi (N=4, CNT_WIDTH=4, HOLD_WIDTH=6, RST_VAL=0).
// Honours DEBOUNCE_LONG_PRESS_EN the same way as the design.
module tb_debounce_multi;

    localparam int   N   = 4;
    localparam int   CW  = 4;
    localparam int   HW  = 6;
    localparam logic RV  = 1'b0;
    localparam int   WIN = 1 << CW;          // cycles a new level must persist
    localparam int   HOLD_MAX = (1 << HW) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn;
    logic [N-1:0] state, rise, fall, long_press;

    int n_chk = 0;
    int n_bad = 0;

    debounce_multi #(.N(N), .CNT_WIDTH(CW), .RST_VAL(RV), .HOLD_WIDTH(HW)) dut (
        .clk(clk), .rst(rst), .btn(btn),
        .state(state), .rise(rise), .fall(fall), .long_press(long_press)
    );

    always #5 clk = ~clk;

    // Reference model: sampled-level history per channel.
    logic [N-1:0] m_s1, m_s2, m_state, m_rise, m_fall, m_lp;
    bit           hist [N][$];
    int           since [N];
    int           held  [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_s1 = {N{RV}}; m_s2 = {N{RV}}; m_state = {N{RV}};
            m_rise = '0; m_fall = '0; m_lp = '0;
            for (int c = 0; c < N; c++) begin
                hist[c].delete(); since[c] = WIN; held[c] = 0;
            end
        end else begin
            for (int c = 0; c < N; c++) begin
                bit all_diff;
                m_rise[c] = 1'b0; m_fall[c] = 1'b0; m_lp[c] = 1'b0;
`ifdef DEBOUNCE_LONG_PRESS_EN
                if (m_state[c] != RV) begin
                    held[c]++;
                    if (held[c] == HOLD_MAX) m_lp[c] = 1'b1;
                end else begin
                    held[c] = 0;
                end
`endif
                hist[c].push_back(m_s2[c]);
                if (hist[c].size() > WIN) void'(hist[c].pop_front());
                since[c]++;
                all_diff = (hist[c].size() == WIN);
                foreach (hist[c][k]) if (hist[c][k] == m_state[c]) all_diff = 1'b0;
                if (all_diff && since[c] >= WIN) begin
                    m_state[c] = ~m_state[c];
                    since[c]   = 0;
                    m_rise[c]  = m_state[c];
                    m_fall[c]  = ~m_state[c];
                end
            end
            m_s2 = m_s1;
            m_s1 = btn;
        end
    endtask

    // One clock: update the model on the edge, compare on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("state", 32'(state), 32'(m_state));
        check("rise",  32'(rise),  32'(m_rise));
        check("fall",  32'(fall),  32'(m_fall));
        check("long_press", 32'(long_press), 32'(m_lp));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Ticks until state[ch] reaches lvl; returns count, or -1 past budget.
    task automatic wait_state(input int ch, input logic lvl, input int budget, output int k);
        k = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (state[ch] == lvl) begin k = i; break; end
        end
    endtask

    int k;
    int rem  [N];
    int lp_cnt, t_rise, t_lp;

    initial begin
        rst = 1'b1;
        btn = '0;
        m_s1 = '0; m_s2 = '0; m_state = '0; m_rise = '0; m_fall = '0; m_lp = '0;
        for (int c = 0; c < N; c++) begin since[c] = WIN; held[c] = 0; end

        // 1. reset held 3 cycles, then released
        ticks(3);
        check("rst_state", 32'(state), 32'(0));
        @(negedge clk); rst = 1'b0;
        ticks(5);
        check("idle_state", 32'(state), 32'(0));

        // 2. clean step on channel 0
        btn[0] = 1'b1;
        wait_state(0, 1'b1, 40, k);
        check("step_latency", 32'(k), 32'(2 + WIN));
        check("step_rise", 32'(rise), 32'(4'b0001));
        ticks(5);
        check("step_others", 32'(state[3:1]), 32'(0));

        // 3. bouncy channel 1: 5 high / 3 low for 60 cycles
        for (int i = 0; i < 60; i++) begin
            btn[1] = ((i % 8) < 5);
            tick();
        end
        btn[1] = 1'b0;
        ticks(20);
        check("bounce_state1", 32'(state[1]), 32'(0));

        // 4. channels 2 and 3 together
        btn[3:2] = 2'b11;
        wait_state(2, 1'b1, 40, k);
        check("pair_rise", 32'(rise[3:2]), 32'(2'b11));
        ticks(40 - k);
        btn[3:2] = 2'b00;
        wait_state(2, 1'b0, 40, k);
        check("pair_fall", 32'(fall[3:2]), 32'(2'b11));

        // 5. reset in the middle of a qualification on channel 0
        btn[0] = 1'b0;
        ticks(40);
        btn[0] = 1'b1;
        ticks(10);
        rst = 1'b1;
        ticks(3);
        check("midrst_state", 32'(state[0]), 32'(0));
        @(negedge clk); rst = 1'b0;
        wait_state(0, 1'b1, 40, k);
        check("midrst_latency", 32'(k), 32'(2 + WIN));

        // 6. long hold on channel 0
        btn[0] = 1'b0;
        ticks(40);
        btn[0] = 1'b1;
        lp_cnt = 0; t_rise = -1; t_lp = -1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (rise[0]) t_rise = i;
            if (long_press[0]) begin lp_cnt++; t_lp = i; end
        end
        btn[0] = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (long_press[0]) lp_cnt++;
        end
`ifdef DEBOUNCE_LONG_PRESS_EN
        check("lp_count", 32'(lp_cnt), 32'(1));
        check("lp_delay", 32'(t_lp - t_rise), 32'(HOLD_MAX));
`else
        check("lp_count", 32'(lp_cnt), 32'(0));
`endif

        // Random bouncing on all channels, with one reset pulse in the middle.
        for (int c = 0; c < N; c++) rem[c] = 0;
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < N; c++) begin
                if (rem[c] == 0) begin
                    btn[c] = 1'($urandom_range(1, 0));
                    rem[c] = ($urandom_range(3, 0) == 0) ? $urandom_range(40, 14)
                                                         : $urandom_range(6, 1);
                end
                rem[c]--;
            end
            rst = (i >= 700 && i < 703);
            tick();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
